// File: rtl/vendor_pkg.sv
// Shared types and constants for the vending-machine button front end.
package vendor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int IDX_C = 0;
    localparam int IDX_F = 1;
    localparam int IDX_P = 2;

    // Fixed priority p > f > c; returns a one-hot grant (or zero).
    function automatic logic [2:0] grant_of(input logic [2:0] req);
        logic [2:0] g;
        g = '0;
        if (req[IDX_P])      g[IDX_P] = 1'b1;
        else if (req[IDX_F]) g[IDX_F] = 1'b1;
        else if (req[IDX_C]) g[IDX_C] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/vendor_button_frontend_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw button; flags the
// cycle in which the debounced level has just risen.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic       level;
    logic       level_q;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            // Any sample that agrees with the current level restarts the count.
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/vendor_button_frontend.sv
// Debounces three vending buttons, queues one request per button and emits
// single-cycle pulses by fixed priority, separated by forced gap cycles.
module vendor_button_frontend
    import vendor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic       btn_f,
    input  logic       btn_p,
    output logic       c,
    output logic       f,
    output logic       p,
    output logic [2:0] pend,
    output logic       busy,
    output logic       drop
);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [2:0] rise;
    logic [2:0] grant;
    logic [3:0] gap_cnt;
    logic [3:0] gap_next;
    state_t     state;
    state_t     state_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
        .clk(clk), .rst(reset), .raw(btn_c), .rise(rise[IDX_C])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_f (
        .clk(clk), .rst(reset), .raw(btn_f), .rise(rise[IDX_F])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_p (
        .clk(clk), .rst(reset), .raw(btn_p), .rise(rise[IDX_P])
    );

    // A finished gap hands straight to the next pending request, so queued
    // presses come out every GAP_CYCLES+1 cycles.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        grant      = '0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    grant      = grant_of(pend);
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = GAP;
                gap_next   = GAP_LAST;
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (|pend) begin
                        grant      = grant_of(pend);
                        state_next = EMIT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            {p, f, c} <= '0;
            pend      <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            {p, f, c} <= grant;
            // A new press on the grant edge re-arms the bit instead of dropping.
            pend      <= (pend & ~grant) | rise;
            drop      <= |(rise & pend & ~grant);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vendor_button_frontend.sv
// Directed bench for vendor_button_frontend: a default instance plus a
// long-gap instance used to hold a request pending long enough to drop a press.
module tb_vendor_button_frontend;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_c = 1'b0, btn_f = 1'b0, btn_p = 1'b0;
    logic       c, f, p, busy, drop;
    logic [2:0] pend;
    logic       btn_c_g = 1'b0, btn_f_g = 1'b0, btn_p_g = 1'b0;
    logic       c_g, f_g, p_g, busy_g, drop_g;
    logic [2:0] pend_g;

    int checks = 0;
    int errors = 0;

    vendor_button_frontend dut (
        .clk(clk), .reset(reset), .btn_c(btn_c), .btn_f(btn_f), .btn_p(btn_p),
        .c(c), .f(f), .p(p), .pend(pend), .busy(busy), .drop(drop)
    );

    vendor_button_frontend #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(15)) dut_g (
        .clk(clk), .reset(reset), .btn_c(btn_c_g), .btn_f(btn_f_g), .btn_p(btn_p_g),
        .c(c_g), .f(f_g), .p(p_g), .pend(pend_g), .busy(busy_g), .drop(drop_g)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt_pulse;
        int cnt_drop;
        logic [7:0] ex;

        // reset state
        #3;
        chk("rst_outs", {3'b0, c, f, p, busy, drop}, 8'h00);
        chk("rst_pend", {5'b0, pend}, 8'h00);
        tick();
        reset = 1'b0;
        idle_wait(2);

        // f held 20 cycles: one pulse after edge 7
        btn_f = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 6) chk("f_pend_e6", {5'b0, pend}, 8'b010);
            chk("f_pulse", {5'b0, p, f, c}, (e == 7) ? 8'b010 : 8'b000);
            if (e >= 7 && e <= 9) chk("f_busy", {7'b0, busy}, (e == 9) ? 8'h0 : 8'h1);
        end
        btn_f = 1'b0;
        cnt_pulse = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (f) cnt_pulse++;
        end
        chk("f_release_nopulse", 8'(cnt_pulse), 8'd0);

        // re-press f gives a second pulse
        btn_f = 1'b1;
        idle_wait(7);
        chk("f_repress_e6", {7'b0, f}, 8'h0);
        tick();
        chk("f_repress_e7", {7'b0, f}, 8'h1);
        btn_f = 1'b0;
        idle_wait(14);

        // three buttons together
        btn_c = 1'b1; btn_f = 1'b1; btn_p = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (e == 6) chk("all_pend_e6", {5'b0, pend}, 8'b111);
            ex = (e == 7) ? 8'b100 : (e == 9) ? 8'b010 : (e == 11) ? 8'b001 : 8'b000;
            chk("all_order", {5'b0, p, f, c}, ex);
            chk("all_busy", {7'b0, busy}, (e >= 7 && e <= 12) ? 8'h1 : 8'h0);
        end
        btn_c = 1'b0; btn_f = 1'b0; btn_p = 1'b0;
        idle_wait(14);

        // short glitch: nothing happens
        cnt_pulse = 0; cnt_drop = 0;
        for (int e = 0; e < 16; e++) begin
            btn_c = (e < 3);
            tick();
            if (c) cnt_pulse++;
            if (drop || pend != 3'b000) cnt_drop++;
        end
        chk("glitch_pulse", 8'(cnt_pulse), 8'd0);
        chk("glitch_pend_drop", 8'(cnt_drop), 8'd0);

        // bounce 111 00 1 0 1 0 then stable: one pulse at stable start + 7
        for (int e = 0; e < 26; e++) begin
            case (e)
                3, 4, 6, 8: btn_c = 1'b0;
                default:    btn_c = 1'b1;
            endcase
            tick();
            chk("bounce_c", {7'b0, c}, (e == 16) ? 8'h1 : 8'h0);
        end
        btn_c = 1'b0;
        idle_wait(14);

        // reset mid-EMIT of f
        btn_f = 1'b1;
        idle_wait(8);
        chk("mid_emit_f", {7'b0, f}, 8'h1);
        #2;
        reset = 1'b1;
        btn_f = 1'b0;
        #1;
        chk("async_rst_outs", {3'b0, c, f, p, busy, drop}, 8'h00);
        chk("async_rst_pend", {5'b0, pend}, 8'h00);
        idle_wait(2);
        reset = 1'b0;
        cnt_pulse = 0;
        for (int e = 0; e < 14; e++) begin
            tick();
            if (f || c || p || busy) cnt_pulse++;
        end
        chk("post_rst_quiet", 8'(cnt_pulse), 8'd0);

        // button held across reset release re-debounces from zero
        btn_c = 1'b1;
        idle_wait(8);
        reset = 1'b1;
        #1;
        chk("held_rst_pend", {5'b0, pend}, 8'h00);
        idle_wait(2);
        reset = 1'b0;
        idle_wait(7);
        chk("held_rst_e6", {7'b0, c}, 8'h0);
        tick();
        chk("held_rst_e7", {7'b0, c}, 8'h1);
        btn_c = 1'b0;
        idle_wait(14);

        // long gap: second c press while pend[0] set is dropped
        btn_p_g = 1'b1;
        cnt_pulse = 0; cnt_drop = 0;
        for (int e = 0; e < 30; e++) begin
            btn_c_g = (e < 4 || e >= 8);
            tick();
            chk("gap_p", {7'b0, p_g}, (e == 7) ? 8'h1 : 8'h0);
            chk("gap_drop", {7'b0, drop_g}, (e == 14) ? 8'h1 : 8'h0);
            chk("gap_c", {7'b0, c_g}, (e == 23) ? 8'h1 : 8'h0);
            if (e == 15) chk("gap_pend_kept", {5'b0, pend_g}, 8'b001);
            if (c_g) cnt_pulse++;
            if (drop_g) cnt_drop++;
        end
        chk("gap_c_count", 8'(cnt_pulse), 8'd1);
        chk("gap_drop_count", 8'(cnt_drop), 8'd1);
        btn_p_g = 1'b0; btn_c_g = 1'b0;
        idle_wait(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
